// File: rtl/lsu.sv
// Single-outstanding load/store unit: one aligned 64-bit bus transaction per op,
// returning extended load data or a store completion to writeback.
module lsu #(
   parameter int XLEN   = 64,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              load_i,
   input  logic              store_i,
   input  logic [2:0]        funct3_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic              mem_wen_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic [STRB_W-1:0] mem_wstrb_o,
   input  logic              mem_rsp_valid_i,
   input  logic              mem_rsp_err_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [XLEN-1:0]   rdata_o,
   output logic              misalign_o,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, OUT = 2'd3} state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic                wen_q, wen_d;
   logic [2:0]          off_q, off_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                mis_q, mis_d;

   logic                illegal_s;
   logic                misal_s;
   logic [STRB_W-1:0]   strb_base_s;
   logic [XLEN-1:0]     shifted_s;
   logic [XLEN-1:0]     ext_s;

   assign ready_o         = (state_q == IDLE);
   assign valid_o         = (state_q == OUT);
   assign mem_req_valid_o = (state_q == REQ);
   assign mem_addr_o      = addr_q;
   assign mem_wen_o       = wen_q;
   assign mem_wdata_o     = wdata_q;
   assign mem_wstrb_o     = strb_q;
   assign rdata_o         = rdata_q;
   assign err_o           = err_q;
   assign misalign_o      = mis_q;

   // Decode of the incoming op: legality, natural alignment and byte-lane base mask.
   always_comb begin
      illegal_s   = (load_i & store_i) | (store_i & funct3_i[2]) |
                    (load_i & (funct3_i == 3'b111));
      misal_s     = 1'b0;
      strb_base_s = 8'h00;
      case (funct3_i[1:0])
         2'b00: begin misal_s = 1'b0;          strb_base_s = 8'h01; end
         2'b01: begin misal_s = addr_i[0];     strb_base_s = 8'h03; end
         2'b10: begin misal_s = |addr_i[1:0];  strb_base_s = 8'h0F; end
         default: begin misal_s = |addr_i[2:0]; strb_base_s = 8'hFF; end
      endcase
   end

   // Align returned doubleword to the accessed byte, then sign/zero-extend.
   always_comb begin
      shifted_s = mem_rdata_i >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  ext_s = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
         3'b001:  ext_s = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
         3'b010:  ext_s = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
         3'b100:  ext_s = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
         3'b101:  ext_s = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
         3'b110:  ext_s = {{(XLEN-32){1'b0}}, shifted_s[31:0]};
         default: ext_s = shifted_s;
      endcase
   end

   // Next-state and datapath capture for the IDLE/REQ/RSP/OUT sequence.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      wen_d    = wen_q;
      off_d    = off_q;
      funct3_d = funct3_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      mis_d    = mis_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               addr_d   = {addr_i[XLEN-1:3], 3'b000};
               wdata_d  = wdata_i << {addr_i[2:0], 3'b000};
               strb_d   = store_i ? (strb_base_s << addr_i[2:0]) : 8'h00;
               wen_d    = store_i;
               off_d    = addr_i[2:0];
               funct3_d = funct3_i;
               rdata_d  = {XLEN{1'b0}};
               err_d    = 1'b0;
               mis_d    = 1'b0;
               if (!load_i && !store_i) begin
                  state_d = OUT;
               end else if (illegal_s) begin
                  err_d   = 1'b1;
                  state_d = OUT;
               end else if (misal_s) begin
                  mis_d   = 1'b1;
                  state_d = OUT;
               end else begin
                  state_d = REQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (mem_req_ready_i) begin
               state_d = RSP;
            end else begin
               state_d = REQ;
            end
         end
         RSP: begin
            if (mem_rsp_valid_i) begin
               err_d   = mem_rsp_err_i;
               rdata_d = (mem_rsp_err_i || wen_q) ? {XLEN{1'b0}} : ext_s;
               state_d = OUT;
            end else begin
               state_d = RSP;
            end
         end
         OUT: begin
            if (ready_i) begin
               state_d = IDLE;
            end else begin
               state_d = OUT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and captured-operand registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         addr_q   <= {XLEN{1'b0}};
         wdata_q  <= {XLEN{1'b0}};
         strb_q   <= {STRB_W{1'b0}};
         wen_q    <= 1'b0;
         off_q    <= 3'b000;
         funct3_q <= 3'b000;
         rdata_q  <= {XLEN{1'b0}};
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         wen_q    <= wen_d;
         off_q    <= off_d;
         funct3_q <= funct3_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         mis_q    <= mis_d;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for lsu: each record drives one op through a
// simple memory model and checks bus signals, latency and writeback result.
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        valid_i, ready_o, load_i, store_i;
   logic [2:0]  funct3_i;
   logic [63:0] addr_i, wdata_i;
   logic        mem_req_valid_o, mem_req_ready_i;
   logic [63:0] mem_addr_o;
   logic        mem_wen_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wstrb_o;
   logic        mem_rsp_valid_i, mem_rsp_err_i;
   logic [63:0] mem_rdata_i;
   logic        valid_o, ready_i;
   logic [63:0] rdata_o;
   logic        misalign_o, err_o;

   int n_cmp = 0;
   int n_err = 0;

   lsu dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
      .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .mem_req_valid_o(mem_req_valid_o),
      .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
      .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_err_i(mem_rsp_err_i),
      .mem_rdata_i(mem_rdata_i), .valid_o(valid_o), .ready_i(ready_i),
      .rdata_o(rdata_o), .misalign_o(misalign_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        rerr;
      logic        fast;
      logic [63:0] e_addr;
      logic [63:0] e_wdata;
      logic [7:0]  e_strb;
      logic        e_wen;
      logic [63:0] e_rdata;
      logic        e_err;
      logic        e_mis;
      int          req_wait;
      int          out_wait;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_req(input vec_t v);
      chk({v.name, " req_valid"}, 64'(mem_req_valid_o), 64'd1);
      chk({v.name, " addr"},      mem_addr_o,           v.e_addr);
      chk({v.name, " wen"},       64'(mem_wen_o),       64'(v.e_wen));
      chk({v.name, " wdata"},     mem_wdata_o,          v.e_wdata);
      chk({v.name, " wstrb"},     64'(mem_wstrb_o),     64'(v.e_strb));
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk_i);
      valid_i  = 1'b1;
      load_i   = v.ld;
      store_i  = v.st;
      funct3_i = v.f3;
      addr_i   = v.addr;
      wdata_i  = v.wdata;
      chk({v.name, " ready_o idle"}, 64'(ready_o), 64'd1);
      @(negedge clk_i);
      valid_i = 1'b0;
      if (!v.fast) begin
         chk_req(v);
         chk({v.name, " valid_o in req"}, 64'(valid_o), 64'd0);
         for (int i = 0; i < v.req_wait; i++) begin
            @(negedge clk_i);
            chk_req(v);
         end
         mem_req_ready_i = 1'b1;
         @(negedge clk_i);
         mem_req_ready_i = 1'b0;
         chk({v.name, " req_valid in rsp"}, 64'(mem_req_valid_o), 64'd0);
         chk({v.name, " valid_o in rsp"},   64'(valid_o),         64'd0);
         mem_rsp_valid_i = 1'b1;
         mem_rsp_err_i   = v.rerr;
         mem_rdata_i     = v.rdata;
         @(negedge clk_i);
         mem_rsp_valid_i = 1'b0;
         mem_rsp_err_i   = 1'b0;
      end else begin
         chk({v.name, " no req"}, 64'(mem_req_valid_o), 64'd0);
      end
      for (int i = 0; i <= v.out_wait; i++) begin
         if (i > 0) @(negedge clk_i);
         chk({v.name, " valid_o"},    64'(valid_o),    64'd1);
         chk({v.name, " ready_o out"}, 64'(ready_o),   64'd0);
         chk({v.name, " rdata_o"},    rdata_o,         v.e_rdata);
         chk({v.name, " err_o"},      64'(err_o),      64'(v.e_err));
         chk({v.name, " misalign_o"}, 64'(misalign_o), 64'(v.e_mis));
         chk({v.name, " req idle"},   64'(mem_req_valid_o), 64'd0);
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      chk({v.name, " valid_o drop"}, 64'(valid_o), 64'd0);
      chk({v.name, " ready_o back"}, 64'(ready_o), 64'd1);
   endtask

   initial begin
      //          name     ld    st    f3      addr                wdata                  rdata                  rerr  fast  e_addr              e_wdata                e_strb e_wen e_rdata               e_err e_mis rw ow
      vecs[0]  = '{"LB",   1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 0, 0};
      vecs[1]  = '{"SW",   1'b0, 1'b1, 3'b010, 64'h0000_0000_8000_0004, 64'h1122_3344, 64'h0, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h1122_3344_0000_0000, 8'hF0, 1'b1, 64'h0, 1'b0, 1'b0, 0, 0};
      vecs[2]  = '{"LHmis",1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0001, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b1, 0, 1};
      vecs[3]  = '{"LWU",  1'b1, 1'b0, 3'b110, 64'h0000_0000_8000_0000, 64'h0, 64'h1234_5678_DEAD_BEEF, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 3, 0};
      vecs[4]  = '{"LDerr",1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_8000_0008, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0, 0, 2};
      vecs[5]  = '{"LW",   1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 1'b0, 64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0, 0, 0};
      vecs[6]  = '{"LHU",  1'b1, 1'b0, 3'b101, 64'h0000_0000_8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0, 1, 0};
      vecs[7]  = '{"LBU",  1'b1, 1'b0, 3'b100, 64'h0000_0000_8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 1'b0, 64'h0000_0000_0000_00AB, 1'b0, 1'b0, 0, 0};
      vecs[8]  = '{"SB",   1'b0, 1'b1, 3'b000, 64'h0000_0000_8000_0005, 64'h5A, 64'h0, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_5A00_0000_0000, 8'h20, 1'b1, 64'h0, 1'b0, 1'b0, 0, 0};
      vecs[9]  = '{"SD",   1'b0, 1'b1, 3'b011, 64'h0000_0000_8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0, 64'h0000_0000_8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 64'h0, 1'b0, 1'b0, 2, 0};
      vecs[10] = '{"ill_st",1'b0,1'b1, 3'b100, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0, 0, 0};
      vecs[11] = '{"ill_ld",1'b1,1'b0, 3'b111, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0, 0, 0};
      vecs[12] = '{"ill_ls",1'b1,1'b1, 3'b000, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0, 0, 0};
      vecs[13] = '{"nonmem",1'b0,1'b0, 3'b011, 64'h0000_0000_8000_0003, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b0, 0, 0};
      vecs[14] = '{"LDmis",1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0004, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b1, 0, 0};
      vecs[15] = '{"SWmis",1'b0, 1'b1, 3'b010, 64'h0000_0000_8000_0002, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b1, 0, 0};
      vecs[16] = '{"LH",   1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0002, 64'h0, 64'h0000_0000_8001_0000, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 0, 0};
      vecs[17] = '{"LD",   1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0018, 64'h0, 64'hCAFE_BABE_1234_5678, 1'b0, 1'b0, 64'h0000_0000_8000_0018, 64'h0, 8'h00, 1'b0, 64'hCAFE_BABE_1234_5678, 1'b0, 1'b0, 0, 0};

      rst_n_i = 1'b0; valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
      funct3_i = 3'b000; addr_i = 64'h0; wdata_i = 64'h0;
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
      mem_rdata_i = 64'h0; ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst ready_o",   64'(ready_o),         64'd1);
      chk("rst valid_o",   64'(valid_o),         64'd0);
      chk("rst req_valid", 64'(mem_req_valid_o), 64'd0);
      chk("rst wstrb",     64'(mem_wstrb_o),     64'd0);
      chk("rst rdata_o",   rdata_o,              64'd0);
      chk("rst err/mis",   64'({err_o, misalign_o}), 64'd0);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      for (int k = 0; k < 18; k++) run_vec(vecs[k]);

      // Reset while waiting for a response, then a stale response arrives in IDLE.
      @(negedge clk_i);
      valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b011;
      addr_i = 64'h0000_0000_8000_0020;
      @(negedge clk_i);
      valid_i = 1'b0; load_i = 1'b0;
      mem_req_ready_i = 1'b1;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      chk("rstmid in rsp", 64'({mem_req_valid_o, valid_o, ready_o}), 64'd0);
      rst_n_i = 1'b0;
      #1;
      chk("rstmid async ready_o", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      chk("late rsp valid_o", 64'(valid_o), 64'd0);
      chk("late rsp ready_o", 64'(ready_o), 64'd1);
      chk("late rsp rdata_o", rdata_o,      64'd0);
      @(negedge clk_i);
      chk("late rsp valid_o+1", 64'(valid_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
